// File: rtl/neg_exp_axil_pkg.sv
// Shared constants and types for the Neg_exp AXI4-Lite register bank.
// Imported by the interface-facing top level and by the register file.
package neg_exp_axil_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG0_OFS = 4'h0;
  localparam logic [3:0] REG1_OFS = 4'h4;
  localparam logic [3:0] REG2_OFS = 4'h8;
  localparam logic [3:0] REG3_OFS = 4'hC;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;

  // Bytes with a clear strobe keep their previous contents.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/neg_exp_axil_slave_if.sv
// AXI4-Lite signal bundle between a bus master (PS or VIP) and the Neg_exp
// register bank; the master/slave modports fix the direction of each wire.
interface neg_exp_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/neg_exp_axil_regfile.sv
// Register storage for the Neg_exp bank: byte-strobed write port, combinational
// read mux, flattened contents and a one-cycle write pulse per register.
module neg_exp_axil_regfile
  import neg_exp_axil_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  reg_idx_t                   wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  reg_idx_t                   rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_en) begin
        regs[wr_idx]         <= byte_merge(regs[wr_idx], wr_data, wr_strb);
        reg_wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  // Read mux sees the pre-write contents, so a same-edge read returns old data.
  assign rd_data = regs[rd_idx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[DATA_W*g +: DATA_W] = regs[g];
  end

endmodule

// File: rtl/neg_exp_axil_slave.sv
// AXI4-Lite responder for the Neg_exp register bank: independent write and read
// channel control in front of neg_exp_axil_regfile.
module neg_exp_axil_slave
  import neg_exp_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_areset,
  neg_exp_axil_slave_if.slave                    s00_axi,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic              rst_done;
  logic              aw_hold;
  logic              w_hold;
  logic              bvalid;
  logic              rvalid;
  reg_idx_t          aw_idx_q;
  logic [DW-1:0]     wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DW-1:0]     rdata;

  logic              awready;
  logic              wready;
  logic              arready;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  reg_idx_t          aw_idx;
  reg_idx_t          ar_idx;
  reg_idx_t          wr_idx;
  logic [DW-1:0]     wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [DW-1:0]     rd_data;
  logic              unused_bits;

  assign aw_idx = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  // Byte-offset bits and protection attributes carry no meaning for this bank.
  assign unused_bits = ^{s00_axi.awaddr[1:0], s00_axi.araddr[1:0],
                         s00_axi.awprot, s00_axi.arprot};

  // Readies are built only from flops, never from the VALID inputs.
  assign awready = rst_done & ~aw_hold & ~bvalid;
  assign wready  = rst_done & ~w_hold  & ~bvalid;
  assign arready = rst_done & ~rvalid;

  assign aw_hs = s00_axi.awvalid & awready;
  assign w_hs  = s00_axi.wvalid  & wready;
  assign ar_hs = s00_axi.arvalid & arready;

  // Commit on the edge that completes the pair, taking each half either from
  // the live handshake or from the copy latched earlier.
  assign commit  = (aw_hold | aw_hs) & (w_hold | w_hs);
  assign wr_idx  = aw_hs ? aw_idx : aw_idx_q;
  assign wr_data = w_hs ? s00_axi.wdata : wdata_q;
  assign wr_strb = w_hs ? s00_axi.wstrb : wstrb_q;

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rst_done <= 1'b0;
      aw_hold  <= 1'b0;
      w_hold   <= 1'b0;
      bvalid   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      rst_done <= 1'b1;
      if (aw_hs) begin
        aw_hold  <= 1'b1;
        aw_idx_q <= aw_idx;
      end
      if (w_hs) begin
        w_hold  <= 1'b1;
        wdata_q <= s00_axi.wdata;
        wstrb_q <= s00_axi.wstrb;
      end
      if (commit) begin
        aw_hold <= 1'b0;
        w_hold  <= 1'b0;
        bvalid  <= 1'b1;
      end else if (bvalid && s00_axi.bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
    end else if (rvalid && s00_axi.rready) begin
      rvalid <= 1'b0;
    end
  end

  neg_exp_axil_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DW)
  ) u_regfile (
    .clk          (s00_axi_aclk),
    .rst          (s00_axi_areset),
    .wr_en        (commit),
    .wr_idx       (wr_idx),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .rd_idx       (ar_idx),
    .rd_data      (rd_data),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse)
  );

  assign s00_axi.awready = awready;
  assign s00_axi.wready  = wready;
  assign s00_axi.bvalid  = bvalid;
  assign s00_axi.bresp   = RESP_OKAY;
  assign s00_axi.arready = arready;
  assign s00_axi.rvalid  = rvalid;
  assign s00_axi.rdata   = rdata;
  assign s00_axi.rresp   = RESP_OKAY;

endmodule
